// File: rtl/pe_pkg.sv
// pe_pkg: shared types and constants for the pe_flex processing element.
package pe_pkg;
  localparam int         CONFIG_W     = 14;
  localparam logic [7:0] IFMAP_OFFSET = 8'h80;

  typedef enum logic [2:0] {
    IDLE, READ_FILTER, READ_IFMAP, READ_IPSUM, CONV, WRITE_OPSUM
  } state_t;

  typedef struct packed {
    logic       depthwise;
    logic       stride2;
    logic [1:0] rs_m1;
    logic       mode;
    logic [1:0] p_m1;
    logic [4:0] f;
    logic [1:0] q_m1;
  } pe_cfg_t;
endpackage

// File: rtl/pe_mac.sv
// pe_mac: registered signed ELEM_W x ELEM_W operands feeding a wrapping PSUM_W accumulate.
// With PE_ZERO_SKIP_EN the operand registers hold on a zero operand and the add is bypassed.
module pe_mac import pe_pkg::*; #(
  parameter int ELEM_W = 8,
  parameter int PSUM_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_ld,
  input  logic signed [ELEM_W-1:0] i_a,
  input  logic signed [ELEM_W-1:0] i_b,
`ifdef PE_ZERO_SKIP_EN
  input  logic                     i_zero,
`endif
  input  logic        [PSUM_W-1:0] i_acc,
  output logic        [PSUM_W-1:0] o_acc
);
  logic signed [ELEM_W-1:0]   r_a, r_b;
  logic signed [2*ELEM_W-1:0] w_prod;

  assign w_prod = r_a * r_b;

`ifdef PE_ZERO_SKIP_EN
  logic r_skip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_skip <= 1'b0;
    end else if (i_ld) begin
      r_skip <= i_zero;
      if (!i_zero) begin
        r_a <= i_a;
        r_b <= i_b;
      end
    end
  end

  assign o_acc = r_skip ? i_acc : i_acc + PSUM_W'(w_prod);
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_ld) begin
      r_a <= i_a;
      r_b <= i_b;
    end
  end

  assign o_acc = i_acc + PSUM_W'(w_prod);
`endif
endmodule

// File: rtl/pe_flex.sv
// pe_flex: row-stationary PE; loads filter/ifmap/ipsum spads, runs one MAC per cycle, streams psums.
// Optional PE_ZERO_SKIP_EN keeps per-entry zero flags so zero operands do not toggle the MAC.
module pe_flex import pe_pkg::*; #(
  parameter int DATA_W       = 32,
  parameter int ELEM_W       = 8,
  parameter int PSUM_W       = 32,
  parameter int IFMAP_DEPTH  = 16,
  parameter int FILTER_DEPTH = 64,
  parameter int PSUM_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pe_en,
  input  logic [CONFIG_W-1:0] i_config,
  input  logic [DATA_W-1:0]   filter,
  input  logic                filter_valid,
  output logic                filter_ready,
  input  logic [DATA_W-1:0]   ifmap,
  input  logic                ifmap_valid,
  output logic                ifmap_ready,
  input  logic [PSUM_W-1:0]   ipsum,
  input  logic                ipsum_valid,
  output logic                ipsum_ready,
  output logic [PSUM_W-1:0]   opsum,
  output logic                opsum_valid,
  input  logic                opsum_ready,
  output logic                busy
);
  localparam int LANES = DATA_W / ELEM_W;
  localparam int FA_W  = $clog2(FILTER_DEPTH);
  localparam int IA_W  = $clog2(IFMAP_DEPTH);
  localparam int PA_W  = $clog2(PSUM_DEPTH);
  localparam int CNT_W = 8;

  state_t            r_state, w_nstate;
  pe_cfg_t           r_cfg;
  logic [ELEM_W-1:0] r_flt  [FILTER_DEPTH];
  logic [ELEM_W-1:0] r_ifm  [IFMAP_DEPTH];
  logic [PSUM_W-1:0] r_psum [PSUM_DEPTH];
  logic [CNT_W-1:0]  r_fcnt, r_icnt, r_pcnt, r_ocnt, r_t, r_ci, r_k;
  logic [4:0]        r_col;
`ifdef PE_ZERO_SKIP_EN
  logic [FILTER_DEPTH-1:0] r_fz;
  logic [IFMAP_DEPTH-1:0]  r_iz;
`endif

  logic [CNT_W-1:0]  w_q, w_p, w_r, w_s, w_qr, w_pqr, w_n, w_c, w_sq;
  logic [CNT_W-1:0]  w_t_n, w_ci_n, w_k_n;
  logic              w_ci_wrap, w_fhs, w_ihs, w_phs, w_ohs, w_ld_first, w_ld;
  logic [FA_W-1:0]   w_fa;
  logic [IA_W-1:0]   w_ia;
  logic [PSUM_W-1:0] w_acc;
  logic              w_unused_mode;

  assign w_q   = CNT_W'(r_cfg.q_m1) + CNT_W'(1);
  assign w_p   = CNT_W'(r_cfg.p_m1) + CNT_W'(1);
  assign w_r   = CNT_W'(r_cfg.rs_m1) + CNT_W'(1);
  assign w_s   = r_cfg.stride2 ? CNT_W'(2) : CNT_W'(1);
  assign w_qr  = w_q * w_r;
  assign w_pqr = w_p * w_qr;
  assign w_sq  = w_s * w_q;
  assign w_n   = r_cfg.depthwise ? w_q : w_p;
  assign w_c   = r_cfg.depthwise ? w_qr : w_pqr;
  assign w_unused_mode = r_cfg.mode;

  assign filter_ready = (r_state == READ_FILTER);
  assign ifmap_ready  = (r_state == READ_IFMAP);
  assign ipsum_ready  = (r_state == READ_IPSUM);
  assign opsum_valid  = (r_state == WRITE_OPSUM);
  assign busy         = (r_state != IDLE);
  assign opsum        = opsum_valid ? r_psum[PA_W'(r_ocnt)] : '0;

  assign w_fhs = filter_valid & filter_ready;
  assign w_ihs = ifmap_valid & ifmap_ready;
  assign w_phs = ipsum_valid & ipsum_ready;
  assign w_ohs = opsum_valid & opsum_ready;

  // Operands are fetched one step ahead: index 0 on the last ipsum beat, t+1 during CONV.
  assign w_t_n      = r_t + CNT_W'(1);
  assign w_ci_wrap  = (r_ci + CNT_W'(1) == w_qr);
  assign w_ci_n     = w_ci_wrap ? '0 : r_ci + CNT_W'(1);
  assign w_k_n      = r_cfg.depthwise ? ((r_k + CNT_W'(1) == w_q) ? '0 : r_k + CNT_W'(1))
                                      : (w_ci_wrap ? r_k + CNT_W'(1) : r_k);
  assign w_ld_first = w_phs && (r_pcnt == w_n - CNT_W'(1));
  assign w_ld       = w_ld_first || (r_state == CONV);
  assign w_fa       = w_ld_first ? '0 : FA_W'(w_t_n);
  assign w_ia       = w_ld_first ? '0 : IA_W'(w_ci_n);

  pe_mac #(.ELEM_W(ELEM_W), .PSUM_W(PSUM_W)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_ld  (w_ld),
    .i_a   (r_flt[w_fa]),
    .i_b   (r_ifm[w_ia]),
`ifdef PE_ZERO_SKIP_EN
    .i_zero(r_fz[w_fa] | r_iz[w_ia]),
`endif
    .i_acc (r_psum[PA_W'(r_k)]),
    .o_acc (w_acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:        if (pe_en) w_nstate = READ_FILTER;
      READ_FILTER: if (w_fhs && (r_fcnt + w_q == w_pqr)) w_nstate = READ_IFMAP;
      READ_IFMAP:  if (w_ihs && (r_icnt + w_q == w_qr)) w_nstate = READ_IPSUM;
      READ_IPSUM:  if (w_ld_first) w_nstate = CONV;
      CONV:        if (r_t == w_c - CNT_W'(1)) w_nstate = WRITE_OPSUM;
      WRITE_OPSUM: if (w_ohs && (r_ocnt == w_n - CNT_W'(1)))
                     w_nstate = (r_col == r_cfg.f) ? IDLE : READ_IFMAP;
      default:     w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg  <= '0;
      r_fcnt <= '0; r_icnt <= '0; r_pcnt <= '0; r_ocnt <= '0;
      r_t    <= '0; r_ci   <= '0; r_k    <= '0; r_col  <= '0;
      r_flt  <= '{default: '0};
      r_ifm  <= '{default: '0};
      r_psum <= '{default: '0};
`ifdef PE_ZERO_SKIP_EN
      r_fz   <= '0;
      r_iz   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (pe_en) begin
          r_cfg  <= i_config;
          r_fcnt <= '0; r_icnt <= '0; r_pcnt <= '0; r_ocnt <= '0;
          r_t    <= '0; r_ci   <= '0; r_k    <= '0; r_col  <= '0;
          r_flt  <= '{default: '0};
          r_ifm  <= '{default: '0};
          r_psum <= '{default: '0};
`ifdef PE_ZERO_SKIP_EN
          r_fz   <= '0;
          r_iz   <= '0;
`endif
        end
        READ_FILTER: if (w_fhs) begin
          for (int i = 0; i < LANES; i++)
            if (CNT_W'(i) < w_q) begin
              r_flt[FA_W'(r_fcnt + CNT_W'(i))] <= filter[i*ELEM_W +: ELEM_W];
`ifdef PE_ZERO_SKIP_EN
              r_fz[FA_W'(r_fcnt + CNT_W'(i))]  <= (filter[i*ELEM_W +: ELEM_W] == '0);
`endif
            end
          r_fcnt <= r_fcnt + w_q;
        end
        READ_IFMAP: if (w_ihs) begin
          for (int i = 0; i < LANES; i++)
            if (CNT_W'(i) < w_q) begin
              r_ifm[IA_W'(r_icnt + CNT_W'(i))] <= ifmap[i*ELEM_W +: ELEM_W] ^ ELEM_W'(IFMAP_OFFSET);
`ifdef PE_ZERO_SKIP_EN
              r_iz[IA_W'(r_icnt + CNT_W'(i))]  <= (ifmap[i*ELEM_W +: ELEM_W] == ELEM_W'(IFMAP_OFFSET));
`endif
            end
          r_icnt <= r_icnt + w_q;
        end
        READ_IPSUM: begin
          r_t  <= '0;
          r_ci <= '0;
          r_k  <= '0;
          if (w_phs) begin
            r_psum[PA_W'(r_pcnt)] <= ipsum;
            r_pcnt <= r_pcnt + CNT_W'(1);
          end
        end
        CONV: begin
          r_psum[PA_W'(r_k)] <= w_acc;
          r_t  <= w_t_n;
          r_ci <= w_ci_n;
          r_k  <= w_k_n;
        end
        WRITE_OPSUM: if (w_ohs) begin
          r_ocnt <= r_ocnt + CNT_W'(1);
          if (r_ocnt == w_n - CNT_W'(1)) begin
            r_ocnt <= '0;
            if (r_col != r_cfg.f) begin
              r_col  <= r_col + 5'd1;
              r_icnt <= r_icnt - w_sq;
              r_pcnt <= '0;
              // Slide the window: drop the oldest S*q entries, zero-fill the top.
              for (int j = 0; j < IFMAP_DEPTH; j++) begin
                if (j + int'(w_sq) < IFMAP_DEPTH) begin
                  r_ifm[j] <= r_ifm[IA_W'(j + int'(w_sq))];
`ifdef PE_ZERO_SKIP_EN
                  r_iz[j]  <= r_iz[IA_W'(j + int'(w_sq))];
`endif
                end else begin
                  r_ifm[j] <= '0;
`ifdef PE_ZERO_SKIP_EN
                  r_iz[j]  <= 1'b1;
`endif
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_flex.sv
// tb_pe_flex: directed scoreboard bench for pe_flex; expected psums are queued at stimulus time.
module tb_pe_flex;
  logic        clk = 1'b0;
  logic        rst, pe_en;
  logic [13:0] i_config;
  logic [31:0] filter, ifmap, ipsum, opsum;
  logic        filter_valid, filter_ready, ifmap_valid, ifmap_ready;
  logic        ipsum_valid, ipsum_ready, opsum_valid, opsum_ready, busy;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  pe_flex dut (
    .clk(clk), .rst(rst), .pe_en(pe_en), .i_config(i_config),
    .filter(filter), .filter_valid(filter_valid), .filter_ready(filter_ready),
    .ifmap(ifmap), .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
    .ipsum(ipsum), .ipsum_valid(ipsum_valid), .ipsum_ready(ipsum_ready),
    .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [13:0] mk(input bit dw, input bit s2, input logic [1:0] rs,
                                     input logic [1:0] p, input logic [4:0] f, input logic [1:0] q);
    return {dw, s2, rs, 1'b0, p, f, q};
  endfunction

  function automatic logic [31:0] pk(input logic [7:0] l0, input logic [7:0] l1,
                                     input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic rdy(input int ch);
    return (ch == 0) ? filter_ready : (ch == 1) ? ifmap_ready : ipsum_ready;
  endfunction

  // Scoreboard monitor: a transfer happens at the next posedge whenever valid && ready here.
  always @(negedge clk) begin
    if (!rst && opsum_valid && opsum_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_opsum: got %0h with nothing expected", opsum);
      end else begin
        chk("opsum", opsum, exp_q.pop_front());
      end
    end
  end

  task automatic send(input int ch, input logic [31:0] d);
    int k = 0;
    case (ch)
      0:       begin filter = d; filter_valid = 1'b1; end
      1:       begin ifmap  = d; ifmap_valid  = 1'b1; end
      default: begin ipsum  = d; ipsum_valid  = 1'b1; end
    endcase
    forever begin
      @(negedge clk);
      if (rdy(ch)) break;
      if (++k > 200) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    filter_valid = 1'b0; ifmap_valid = 1'b0; ipsum_valid = 1'b0;
  endtask

  task automatic start(input logic [13:0] c);
    i_config = c; pe_en = 1'b1;
    @(posedge clk); #1;
    pe_en = 1'b0;
    chk("start_filter_ready", {31'd0, filter_ready}, 32'd1);
  endtask

  // Called right after the last ipsum handshake; counts edges until opsum_valid.
  task automatic conv_lat(input int c);
    int k = 0;
    while (!opsum_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("conv_latency", k, c);
  endtask

  task automatic wait_done();
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_pending", exp_q.size(), 32'd0);
  endtask

  task automatic run_a(input bit exp_out);
    start(mk(1'b0, 1'b0, 2'd2, 2'd0, 5'd0, 2'd0));
    send(0, pk(8'd2, 8'h55, 8'h55, 8'h55));
    send(0, pk(8'd3, 8'h55, 8'h55, 8'h55));
    send(0, pk(8'd4, 8'h55, 8'h55, 8'h55));
    send(1, pk(8'h81, 8'h00, 8'h00, 8'h00));
    send(1, pk(8'h82, 8'h00, 8'h00, 8'h00));
    send(1, pk(8'h83, 8'h00, 8'h00, 8'h00));
    if (exp_out) exp_q.push_back(32'd30);
    send(2, 32'd10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pe_en = 1'b0; i_config = '0;
    filter = '0; ifmap = '0; ipsum = '0;
    filter_valid = 1'b0; ifmap_valid = 1'b0; ipsum_valid = 1'b0; opsum_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_filter_ready", {31'd0, filter_ready}, 32'd0);
    chk("rst_ifmap_ready",  {31'd0, ifmap_ready},  32'd0);
    chk("rst_ipsum_ready",  {31'd0, ipsum_ready},  32'd0);
    chk("rst_opsum_valid",  {31'd0, opsum_valid},  32'd0);
    chk("rst_opsum",        opsum,                 32'd0);
    chk("rst_busy",         {31'd0, busy},         32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Standard q=1 p=1 R=3: 10 + 2*1 + 3*2 + 4*3
    run_a(1'b1);
    conv_lat(3);
    @(posedge clk); #1;
    chk("a_idle_after_last", {31'd0, busy}, 32'd0);
    wait_done();

    // Depthwise q=4 R=1
    start(mk(1'b1, 1'b0, 2'd0, 2'd0, 5'd0, 2'd3));
    send(0, pk(8'd1, 8'd2, 8'd3, 8'd4));
    send(1, pk(8'h82, 8'h82, 8'h82, 8'h82));
    exp_q.push_back(32'd2); exp_q.push_back(32'd4);
    exp_q.push_back(32'd6); exp_q.push_back(32'd8);
    repeat (4) send(2, 32'd0);
    conv_lat(4);
    wait_done();

    // Stride 2, q=1 R=3 F=1: windows {1,2,3} then {3,4,5}
    start(mk(1'b0, 1'b1, 2'd2, 2'd0, 5'd1, 2'd0));
    repeat (3) send(0, pk(8'd1, 8'hAA, 8'hAA, 8'hAA));
    send(1, pk(8'h81, 8'h00, 8'h00, 8'h00));
    send(1, pk(8'h82, 8'h00, 8'h00, 8'h00));
    send(1, pk(8'h83, 8'h00, 8'h00, 8'h00));
    exp_q.push_back(32'd6);
    send(2, 32'd0);
    send(1, pk(8'h84, 8'h00, 8'h00, 8'h00));
    send(1, pk(8'h85, 8'h00, 8'h00, 8'h00));
    chk("c_refill_two_beats", {31'd0, ifmap_ready}, 32'd0);
    chk("c_ipsum_ready",      {31'd0, ipsum_ready}, 32'd1);
    exp_q.push_back(32'd12);
    send(2, 32'd0);
    conv_lat(3);
    wait_done();

    // Backpressure, standard p=4 q=1 R=1, ifmap 5, filters 1,-2,3,4
    opsum_ready = 1'b0;
    start(mk(1'b0, 1'b0, 2'd0, 2'd3, 5'd0, 2'd0));
    send(0, pk(8'd1,  8'h00, 8'h00, 8'h00));
    send(0, pk(8'hFE, 8'h00, 8'h00, 8'h00));
    send(0, pk(8'd3,  8'h00, 8'h00, 8'h00));
    send(0, pk(8'd4,  8'h00, 8'h00, 8'h00));
    send(1, pk(8'h85, 8'h00, 8'h00, 8'h00));
    exp_q.push_back(32'd105); exp_q.push_back(32'd190);
    exp_q.push_back(32'd315); exp_q.push_back(32'd420);
    send(2, 32'd100); send(2, 32'd200); send(2, 32'd300); send(2, 32'd400);
    conv_lat(4);
    pe_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("d_hold_opsum", opsum, 32'd105);
      chk("d_hold_valid", {31'd0, opsum_valid}, 32'd1);
    end
    @(posedge clk); #1;
    pe_en = 1'b0;
    opsum_ready = 1'b1;
    wait_done();

    // Standard q=2 p=2 R=2, signed data, upper lanes dropped
    start(mk(1'b0, 1'b0, 2'd1, 2'd1, 5'd0, 2'd1));
    send(0, pk(8'd1, 8'd2, 8'h99, 8'h99));
    send(0, pk(8'd3, 8'd4, 8'h99, 8'h99));
    send(0, pk(8'd5, 8'd6, 8'h99, 8'h99));
    send(0, pk(8'd7, 8'd8, 8'h99, 8'h99));
    send(1, pk(8'h81, 8'h7F, 8'h11, 8'h22));
    send(1, pk(8'h82, 8'h7E, 8'h33, 8'h44));
    exp_q.push_back(32'd997); exp_q.push_back(32'hFFFF_FFFD);
    send(2, 32'd1000); send(2, 32'd0);
    conv_lat(8);
    wait_done();

    // All-zero filters leave ipsums unchanged; cycle count unchanged
    start(mk(1'b0, 1'b0, 2'd1, 2'd1, 5'd0, 2'd1));
    repeat (4) send(0, pk(8'd0, 8'd0, 8'h33, 8'h33));
    send(1, pk(8'h00, 8'hFF, 8'h01, 8'h02));
    send(1, pk(8'h80, 8'h10, 8'h03, 8'h04));
    exp_q.push_back(32'd7); exp_q.push_back(32'hFFFF_FFF7);
    send(2, 32'd7); send(2, 32'hFFFF_FFF7);
    conv_lat(8);
    wait_done();

    // Reset in the middle of CONV, then a clean rerun
    run_a(1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("g_rst_busy",         {31'd0, busy},         32'd0);
    chk("g_rst_opsum_valid",  {31'd0, opsum_valid},  32'd0);
    chk("g_rst_opsum",        opsum,                 32'd0);
    chk("g_rst_readies",      {29'd0, filter_ready, ifmap_ready, ipsum_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_a(1'b1);
    conv_lat(3);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pe_flex.md
# pe_flex

Second-generation row-stationary processing element for the PE array. It loads packed filter and ifmap words into local scratchpads and accepts input partial sums. It then runs one signed 8x8 MAC per cycle over a sliding 1-D window and streams output partial sums. Compared with the first-generation PE it is parametrised in bus, element and psum widths and in scratchpad depths, and it adds stride-2 window advance.

## Interface
- DATA_W, 32, width of the ifmap/filter bus
- ELEM_W, 8, width of one ifmap/filter element; LANES = DATA_W/ELEM_W
- PSUM_W, 32, width of a psum element and of the ipsum/opsum ports
- IFMAP_DEPTH, 16, ifmap spad entries (must be ≥ 4·4)
- FILTER_DEPTH, 64, filter spad entries (must be ≥ 4·4·4)
- PSUM_DEPTH, 4, psum spad entries
- Ports:
  - clk  in  1  clock
  - rst  in  1  asynchronous, active-high reset
  - pe_en  in  1  start request; sampled in IDLE only
  - i_config  in  14  {depthwise[13], stride2[12], rs_m1[11:10], mode[9], p_m1[8:7], F[6:2], q_m1[1:0]}
  - filter, filter_valid, filter_ready  in/in/out  DATA_W/1/1  packed filter beats
  - ifmap, ifmap_valid, ifmap_ready  in/in/out  DATA_W/1/1  packed ifmap beats (unsigned, offset 128)
  - ipsum, ipsum_valid, ipsum_ready  in/in/out  PSUM_W/1/1  input psums
  - opsum, opsum_valid, opsum_ready  out/out/in  PSUM_W/1/1  output psums
  - busy  out  1  high whenever the state is not IDLE

## Operation
- Decoded fields: q = q_m1+1, p = p_m1+1, R = rs_m1+1, S = stride2 ? 2 : 1. F is the last output-column index.
- A transfer occurs on a cycle where valid && ready. Each ready is a pure decode of the registered state. Valid inputs presented outside their state are ignored.
- IDLE:
  - When pe_en is high, i_config is latched, all counters and spads are cleared, and the FSM moves to READ_FILTER.
  - pe_en asserted while busy is ignored.
- READ_FILTER:
  - Each beat writes lanes 0..q-1 to filter_spad[fcnt+i], then fcnt += q. Lanes ≥ q are dropped.
  - Exit to READ_IFMAP when fcnt == p·q·R.
- READ_IFMAP:
  - Each beat writes (lane ^ 0x80), read as signed, to ifmap_spad[icnt+i], then icnt += q.
  - Exit to READ_IPSUM when icnt == q·R.
- READ_IPSUM:
  - Each beat writes psum_spad[pcnt], then pcnt++. N = depthwise ? q : p.
  - Exit to CONV on the beat where pcnt == N-1.
- CONV: one MAC per cycle, psum_spad[k] += sext(filter·ifmap), wrapping modulo 2^PSUM_W.
  - Standard mode: p·q·R cycles. Filter index runs 0..pqR-1, ifmap index runs (filter index mod qR), k = filter index div qR.
  - Depthwise mode: q·R cycles. Filter index = ifmap index = t, k = t mod q.
- WRITE_OPSUM:
  - opsum = psum_spad[ocnt] and opsum_valid = 1. ocnt increments on each handshake.
  - After the N-th handshake, if col == F the FSM goes to IDLE.
  - Otherwise: col++, ifmap_spad shifts down by S·q entries with zero fill, icnt -= S·q, pcnt and ocnt clear, and the FSM goes to READ_IFMAP. The refill therefore takes S beats.
- Illegal configurations (undefined results, no hang requirement): S = 2 with R = 1.
- Reset mid-operation: immediate return to IDLE; all spads, counters and outputs cleared.

## Timing
- Reset values: all readies 0, opsum_valid 0, opsum 0, busy 0, state IDLE.
- pe_en sampled at edge n gives filter_ready = 1 in cycle n+1.
- Read phases accept one beat per cycle when valid is held high (zero bubbles).
- The last ipsum beat at edge n gives the first CONV cycle at n+1, and opsum_valid at n+1+C, where C is the CONV cycle count.
- CONV cycle count is fixed and independent of data and of the zero-skip macro.
- opsum_valid and opsum are stable while opsum_ready is low. One output per cycle when opsum_ready is held high.
- Last WRITE_OPSUM handshake at edge n: ifmap_ready = 1 at n+1, or busy = 0 at n+1 if col == F.

## Configuration
- PE_ZERO_SKIP_EN defined:
  - Per-entry zero flags are stored for both operands. A filter element is zero when its value is 0; an ifmap element is zero when its raw input byte is 0x80.
  - Flags are written and shifted together with their data.
  - When either flag is set, the multiplier operand registers hold their values (no toggling) and the accumulate is suppressed.
  - Results and cycle counts are identical to the undefined case.
- Undefined: no flags are kept; every CONV cycle multiplies and accumulates.

## Structure
- pe_pkg:
  - state_t enum: IDLE, READ_FILTER, READ_IFMAP, READ_IPSUM, CONV, WRITE_OPSUM.
  - pe_cfg_t packed struct matching the i_config layout.
  - CONFIG_W = 14 and IFMAP_OFFSET = 8'h80.
- Sub-module pe_mac: signed ELEM_W×ELEM_W multiplier plus PSUM_W adder, with the operand-hold gating under PE_ZERO_SKIP_EN.

## Test plan
- Standard mode, q=1, p=1, R=3, F=0: filter beats 2,3,4; ifmap raw bytes 0x81,0x82,0x83; ipsum 10. Expect one opsum = 10+2+6+12 = 30, then busy = 0.
- Depthwise, q=4, R=1: filter beat {1,2,3,4}, ifmap raw {0x82,0x82,0x82,0x82}, ipsums 0,0,0,0. Expect opsums 2,4,6,8.
- Stride 2, q=1, R=3, F=1: ifmap values 1..5, all filter elements 1. Expect column sums 6 then 12, and exactly 2 refill beats between the two columns.
- Backpressure: hold opsum_ready low for 5 cycles. opsum stays constant with opsum_valid high; each psum appears exactly once after release.
- Zero skip: with all filter elements 0, opsums equal the ipsums unchanged. Cycle count matches the build without PE_ZERO_SKIP_EN.
- Assert rst during CONV: all outputs 0 in the same cycle. A subsequent run with pe_en produces correct results.
